// File: rtl/freedual_pkg.sv
// Shared types and dual-rail word helpers for the freedual merge slice.
// Helpers take a zero-extended word plus the logical width actually in use.
package freedual_pkg;

    localparam int RAIL0        = 0;
    localparam int RAIL1        = 1;
    localparam int DR_MAX_WIDTH = 32;
    localparam int DR_MAX_RAILS = 2 * DR_MAX_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } fsmState_e;

    function automatic logic dr_is_data(input logic [DR_MAX_RAILS-1:0] word, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if (i < width) ok = ok & (word[2*i+RAIL0] ^ word[2*i+RAIL1]);
            else           ok = ok;
        end
        return ok;
    endfunction

    function automatic logic dr_is_null(input logic [DR_MAX_RAILS-1:0] word, input int width);
        logic any;
        any = 1'b0;
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if (i < width) any = any | word[2*i+RAIL0] | word[2*i+RAIL1];
            else           any = any;
        end
        return ~any;
    endfunction

    function automatic logic dr_has_illegal(input logic [DR_MAX_RAILS-1:0] word, input int width);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if (i < width) bad = bad | (word[2*i+RAIL0] & word[2*i+RAIL1]);
            else           bad = bad;
        end
        return bad;
    endfunction

endpackage

// File: rtl/freedual_rr_pick.sv
// Combinational picker: first requester at or after ptr (cyclic).
// FREEDUAL_MERGE_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module freedual_rr_pick #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx
);

    int startS;

`ifdef FREEDUAL_MERGE_RR_EN
    assign startS = int'(ptr);
`else
    logic unusedPtrS;
    assign unusedPtrS = ^ptr;
    assign startS     = 32'sd0;
`endif

    // scan the channels in cyclic order from the start point, keep the first hit
    always_comb begin
        logic found;
        logic hit;
        int   c;
        found = 1'b0;
        hit   = 1'b0;
        c     = 32'sd0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            c        = (startS + k) % N_CH;
            hit      = req[c] & ~found;
            grant[c] = hit;
            if (hit) idx = CW'(c);
            else     idx = idx;
            found    = found | hit;
        end
    end

endmodule

// File: rtl/freedual_merge_n.sv
// N-channel dual-rail four-phase merge onto one output channel with source tag.
// Build macro FREEDUAL_MERGE_RR_EN enables round-robin; default is fixed priority.
module freedual_merge_n
    import freedual_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(N_CH)  // derived, leave at default
) (
    input  logic                    clk,
    input  logic                    init,
    input  logic [N_CH*2*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]         in_comp,
    output logic [2*WIDTH-1:0]      out_data,
    output logic [CW-1:0]           out_ch,
    input  logic                    out_comp,
    output logic                    err
);

    localparam int RAILS = 2 * WIDTH;

    fsmState_e       stateR;
    logic [CW-1:0]   gR;
    logic [CW-1:0]   ptrS;
    logic [CW-1:0]   pickIdxS;
    logic [N_CH-1:0] reqS;
    logic [N_CH-1:0] illegalS;
    logic [N_CH-1:0] pickGrantS;
    logic            grantNullS;
    logic            releaseS;

    // classify every source channel as DATA and/or carrying an illegal pair
    always_comb begin
        reqS     = '0;
        illegalS = '0;
        for (int c = 0; c < N_CH; c++) begin
            reqS[c]     = dr_is_data(DR_MAX_RAILS'(in_data[c*RAILS +: RAILS]), WIDTH);
            illegalS[c] = dr_has_illegal(DR_MAX_RAILS'(in_data[c*RAILS +: RAILS]), WIDTH);
        end
    end

    assign grantNullS = dr_is_null(DR_MAX_RAILS'(in_data[int'(gR)*RAILS +: RAILS]), WIDTH);
    assign releaseS   = (stateR == DRAIN) && grantNullS && !out_comp;

    freedual_rr_pick #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_pick (
        .req   (reqS),
        .ptr   (ptrS),
        .grant (pickGrantS),
        .idx   (pickIdxS)
    );

`ifdef FREEDUAL_MERGE_RR_EN
    logic [CW-1:0] ptrR;

    // move the round-robin start just past the channel whose handshake completed
    always_ff @(posedge clk or posedge init) begin
        if (init)          ptrR <= '0;
        else if (releaseS) ptrR <= (int'(gR) == N_CH - 1) ? '0 : gR + CW'(1);
        else               ptrR <= ptrR;
    end

    assign ptrS = ptrR;
`else
    assign ptrS = '0;
`endif

    // transfer FSM: grant, wait for consumer, then wait for source NULL
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            stateR   <= IDLE;
            out_data <= '0;
            in_comp  <= '0;
            out_ch   <= '0;
            gR       <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | (|illegalS);
            case (stateR)
                IDLE: begin
                    if ((|pickGrantS) && !out_comp) begin
                        out_data <= in_data[int'(pickIdxS)*RAILS +: RAILS];
                        out_ch   <= pickIdxS;
                        gR       <= pickIdxS;
                        stateR   <= SEND;
                    end
                end
                SEND: begin
                    if (out_comp) begin
                        in_comp[gR] <= 1'b1;
                        out_data    <= '0;
                        stateR      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // a source re-presenting DATA without passing NULL keeps us here
                    if (releaseS) begin
                        in_comp <= '0;
                        stateR  <= IDLE;
                    end
                end
                default: begin
                    stateR   <= IDLE;
                    out_data <= '0;
                    in_comp  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freedual_merge_n.sv
// Directed bench for freedual_merge_n (N_CH=4, WIDTH=8); expectations follow
// FREEDUAL_MERGE_RR_EN when the bundle is built with it.
module tb_freedual_merge_n;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CW    = 2;

    logic                    clk = 1'b0;
    logic                    init;
    logic [N_CH*2*WIDTH-1:0] in_data;
    logic [N_CH-1:0]         in_comp;
    logic [2*WIDTH-1:0]      out_data;
    logic [CW-1:0]           out_ch;
    logic                    out_comp;
    logic                    err;

    int passCount  = 0;
    int totalCount = 0;

    freedual_merge_n #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .init     (init),
        .in_data  (in_data),
        .in_comp  (in_comp),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_comp (out_comp),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [7:0] v);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic setCh(input int c, input logic [15:0] w);
        in_data[c*16 +: 16] = w;
    endtask

    task automatic doReset();
        init     = 1'b1;
        in_data  = '0;
        out_comp = 1'b0;
        tick();
        tick();
        init = 1'b0;
    endtask

    // one full handshake: grant, consumer ack, source NULL + consumer release
    task automatic serve(input string tag, input int ch, input logic [15:0] word,
                         input logic [15:0] reWord);
        tick();
        check({tag, "_ch"}, out_ch, ch);
        check({tag, "_data"}, out_data, word);
        check({tag, "_comp0"}, in_comp, 32'd0);
        out_comp = 1'b1;
        tick();
        check({tag, "_ack"}, in_comp, 32'd1 << ch);
        check({tag, "_null"}, out_data, 32'd0);
        setCh(ch, 16'h0000);
        out_comp = 1'b0;
        tick();
        check({tag, "_rel"}, in_comp, 32'd0);
        setCh(ch, reWord);
    endtask

    initial begin
        logic [15:0] bad;
        logic [7:0]  vals [4];
        int          expCh;

        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;

        doReset();
        check("rst_data", out_data, 32'd0);
        check("rst_comp", in_comp, 32'd0);
        check("rst_ch", out_ch, 32'd0);
        check("rst_err", err, 32'd0);

        // single transfer, 0xA5 on channel 2 encodes to 16'h9966
        setCh(2, enc(8'hA5));
        serve("single", 2, 16'h9966, 16'h0000);

        // all four channels at once; served channel re-presents immediately
        doReset();
        for (int c = 0; c < 4; c++) setCh(c, enc(vals[c]));
        for (int i = 0; i < 5; i++) begin
`ifdef FREEDUAL_MERGE_RR_EN
            expCh = i % 4;
`else
            expCh = 0;
`endif
            serve($sformatf("multi%0d", i), expCh, enc(vals[expCh]), enc(vals[expCh]));
        end
        check("multi_err", err, 32'd0);

        // illegal pair on bit 3 of channel 1
        doReset();
        bad      = enc(8'h5A);
        bad[7:6] = 2'b11;
        setCh(1, bad);
        tick();
        check("ill_err", err, 32'd1);
        check("ill_nogrant", out_data, 32'd0);
        check("ill_comp", in_comp, 32'd0);
        setCh(3, enc(8'hC3));
        serve("ill_ch3", 3, enc(8'hC3), 16'h0000);
        setCh(1, 16'h0000);
        tick();
        check("ill_sticky", err, 32'd1);

        // consumer stall in SEND
        setCh(0, enc(8'h3C));
        tick();
        check("stall_grant", out_data, enc(8'h3C));
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("stall%0d", i), {out_data, out_ch, in_comp},
                  {enc(8'h3C), 2'd0, 4'd0});
        end
        out_comp = 1'b1;
        tick();
        check("stall_ack", in_comp, 32'd1);

        // source keeps DATA in DRAIN: nothing forwarded, still acknowledged
        out_comp = 1'b0;
        tick();
        check("drain_hold_comp", in_comp, 32'd1);
        check("drain_hold_data", out_data, 32'd0);

        // asynchronous init during DRAIN, pending source re-granted afterwards
        init = 1'b1;
        #1;
        check("init_data", out_data, 32'd0);
        check("init_comp", in_comp, 32'd0);
        check("init_err", err, 32'd0);
        init = 1'b0;
        tick();
        check("regrant_data", out_data, enc(8'h3C));
        check("regrant_ch", out_ch, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
